// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the 16-bit pipelined CPU. It sits between execute
// and write-back. It holds the EX/MEM register (S1), runs loads and stores
// against data memory over a variable-latency req/ack handshake, and produces
// the registered MEM/WB bundle (S2). While an access is outstanding, upstream
// is stalled. A wait watchdog moves the stage into a sticky error state if
// memory stops answering.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   ex_valid               EX presents a valid instruction
//   ex_dst                 ALU result / memory address for load and store
//   ex_sdata               store data
//   ex_mem_rd, ex_mem_wr   load / store flags (both set is treated as store)
//   ex_rf_we, ex_rf_dst    register-file write enable and destination
//   ex_hlt                 halt instruction
//   stall                  upstream must hold; EX inputs ignored while high
//   dm_req, dm_we          memory request, 1 = write
//   dm_addr, dm_wdata      memory address and write data
//   dm_ack, dm_rdata       memory completion, read data valid with ack
//   wb_valid, wb_data      MEM/WB bundle valid and write-back value
//   wb_rf_we, wb_rf_dst    register-file write enable and destination
//   wb_hlt                 halt reached write-back
//   mem_err                sticky memory-timeout error
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_dst,
  input  logic [DATA_W-1:0] ex_sdata,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic              ex_rf_we,
  input  logic [REG_AW-1:0] ex_rf_dst,
  input  logic              ex_hlt,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_rf_we,
  output logic [REG_AW-1:0] wb_rf_dst,
  output logic              wb_hlt,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  // Controller state
  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic        mem_err_q;

  // S1: EX/MEM register
  logic              s1_valid_q,  s1_valid_d;
  logic [DATA_W-1:0] s1_dst_q,    s1_dst_d;
  logic [DATA_W-1:0] s1_sdata_q,  s1_sdata_d;
  logic              s1_mem_rd_q, s1_mem_rd_d;
  logic              s1_mem_wr_q, s1_mem_wr_d;
  logic              s1_rf_we_q,  s1_rf_we_d;
  logic [REG_AW-1:0] s1_rf_dst_q, s1_rf_dst_d;
  logic              s1_hlt_q,    s1_hlt_d;

  // S2: MEM/WB register
  logic              wb_valid_q,  wb_valid_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic              wb_rf_we_q,  wb_rf_we_d;
  logic [REG_AW-1:0] wb_rf_dst_q, wb_rf_dst_d;
  logic              wb_hlt_q,    wb_hlt_d;

  // Handshake decode
  logic memop;
  logic in_err;
  logic ack_ok;
  logic waiting;
  logic timeout;
  logic stall_w;
  logic s1_is_load;
  logic s1_is_store;

  assign memop   = s1_valid_q & (s1_mem_rd_q | s1_mem_wr_q);
  assign in_err  = (state_q == ST_ERR);
  assign dm_req  = memop & ~in_err;

  // An ack only counts while a request is actually outstanding.
  assign ack_ok  = dm_req & dm_ack;
  assign waiting = dm_req & ~dm_ack;

  // The counter already holds the number of completed waiting cycles, so
  // this cycle is the MAX_WAIT-th one when the count sits one below the
  // limit. An ack in that same cycle takes priority because waiting is low.
  assign timeout = waiting & (wait_cnt_q >= (MaxWaitC - 8'd1));

  assign stall_w = waiting | in_err;
  assign stall   = stall_w;

  assign s1_is_store = s1_valid_q & s1_mem_wr_q;
  assign s1_is_load  = s1_valid_q & s1_mem_rd_q;

  assign dm_we    = s1_mem_wr_q;
  assign dm_addr  = s1_dst_q;
  assign dm_wdata = s1_sdata_q;

  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_rf_we  = wb_rf_we_q;
  assign wb_rf_dst = wb_rf_dst_q;
  assign wb_hlt    = wb_hlt_q;
  assign mem_err   = mem_err_q;

  // S1 next state: capture EX whenever the stage is not stalled, otherwise
  // hold so the memory interface stays stable until ack or timeout. A
  // load/store conflict is normalised to a store right at capture.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_dst_d    = s1_dst_q;
    s1_sdata_d  = s1_sdata_q;
    s1_mem_rd_d = s1_mem_rd_q;
    s1_mem_wr_d = s1_mem_wr_q;
    s1_rf_we_d  = s1_rf_we_q;
    s1_rf_dst_d = s1_rf_dst_q;
    s1_hlt_d    = s1_hlt_q;
    if (!stall_w) begin
      s1_valid_d  = ex_valid;
      s1_dst_d    = ex_dst;
      s1_sdata_d  = ex_sdata;
      s1_mem_rd_d = ex_mem_rd & ~ex_mem_wr;
      s1_mem_wr_d = ex_mem_wr;
      s1_rf_we_d  = ex_rf_we;
      s1_rf_dst_d = ex_rf_dst;
      s1_hlt_d    = ex_hlt;
    end
  end

  // S2 next state: a bubble by default so write-back never sees the same
  // instruction twice during a stall. Enables are qualified by s1_valid so
  // an empty S1 can never leak a write or halt into write-back.
  always_comb begin
    wb_valid_d  = 1'b0;
    wb_rf_we_d  = 1'b0;
    wb_hlt_d    = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rf_dst_d = wb_rf_dst_q;
    if (!stall_w) begin
      wb_valid_d  = s1_valid_q;
      wb_rf_dst_d = s1_rf_dst_q;
      wb_hlt_d    = s1_valid_q & s1_hlt_q;
      if (s1_is_store) begin
        wb_data_d  = s1_dst_q;
        wb_rf_we_d = 1'b0;
      end else if (s1_is_load) begin
        wb_data_d  = dm_rdata;
        wb_rf_we_d = s1_rf_we_q;
      end else begin
        wb_data_d  = s1_dst_q;
        wb_rf_we_d = s1_valid_q & s1_rf_we_q;
      end
    end
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_dst_q    <= '0;
      s1_sdata_q  <= '0;
      s1_mem_rd_q <= 1'b0;
      s1_mem_wr_q <= 1'b0;
      s1_rf_we_q  <= 1'b0;
      s1_rf_dst_q <= '0;
      s1_hlt_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rf_we_q  <= 1'b0;
      wb_rf_dst_q <= '0;
      wb_hlt_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dst_q    <= s1_dst_d;
      s1_sdata_q  <= s1_sdata_d;
      s1_mem_rd_q <= s1_mem_rd_d;
      s1_mem_wr_q <= s1_mem_wr_d;
      s1_rf_we_q  <= s1_rf_we_d;
      s1_rf_dst_q <= s1_rf_dst_d;
      s1_hlt_q    <= s1_hlt_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rf_we_q  <= wb_rf_we_d;
      wb_rf_dst_q <= wb_rf_dst_d;
      wb_hlt_q    <= wb_hlt_d;
    end
  end

  // Access controller and wait watchdog. The counter counts every cycle a
  // request is left unanswered, including the first one seen in RUN, and
  // stops moving once ERR is reached. ERR is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (waiting) begin
            wait_cnt_q <= 8'd1;
            if (timeout) begin
              state_q   <= ST_ERR;
              mem_err_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            wait_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (!memop || ack_ok) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else begin
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (timeout) begin
              state_q   <= ST_ERR;
              mem_err_q <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          state_q   <= ST_ERR;
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Scoreboard bench for mem_stage. A sampler records every instruction the
// stage accepts and derives its write-back result from a program-order
// memory image; a memory responder with random or forced latency serves
// dm_req and checks each request against the expected access; a monitor
// pops the write-back scoreboard whenever wb_valid is seen.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int MaxWait = 15;

  typedef struct {
    logic [15:0] data;
    logic        rfWe;
    logic [3:0]  rfDst;
    logic        hlt;
  } wbExp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } memExp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_dst = '0;
  logic [15:0] ex_sdata = '0;
  logic        ex_mem_rd = 1'b0;
  logic        ex_mem_wr = 1'b0;
  logic        ex_rf_we = 1'b0;
  logic [3:0]  ex_rf_dst = '0;
  logic        ex_hlt = 1'b0;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack = 1'b0;
  logic [15:0] dm_rdata = '0;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        wb_rf_we;
  logic [3:0]  wb_rf_dst;
  logic        wb_hlt;
  logic        mem_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  wbExp_t  sbQ[$];
  memExp_t memQ[$];
  int      accCycLog[$];
  int      wbCycLog[$];
  logic [15:0] refMem [256];
  logic [15:0] dmMem  [256];

  bit accFlag = 0;
  int accCnt = 0;
  int stallCnt = 0;
  int reqCnt = 0;
  int wbCnt = 0;
  int hltCnt = 0;
  int forceLat = -1;

  bit      busy = 0;
  int      left = 0;
  logic [15:0] reqAddr, reqWdata;
  logic    reqWe;
  memExp_t respItem;
  wbExp_t  monItem;

  mem_stage #(.DATA_W(16), .REG_AW(4), .MAX_WAIT(MaxWait)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_dst    (ex_dst),
    .ex_sdata  (ex_sdata),
    .ex_mem_rd (ex_mem_rd),
    .ex_mem_wr (ex_mem_wr),
    .ex_rf_we  (ex_rf_we),
    .ex_rf_dst (ex_rf_dst),
    .ex_hlt    (ex_hlt),
    .stall     (stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_rf_we  (wb_rf_we),
    .wb_rf_dst (wb_rf_dst),
    .wb_hlt    (wb_hlt),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stall"},     stall,     0);
    checkOutput({tag, "_dm_req"},    dm_req,    0);
    checkOutput({tag, "_dm_we"},     dm_we,     0);
    checkOutput({tag, "_dm_addr"},   dm_addr,   0);
    checkOutput({tag, "_dm_wdata"},  dm_wdata,  0);
    checkOutput({tag, "_wb_valid"},  wb_valid,  0);
    checkOutput({tag, "_wb_data"},   wb_data,   0);
    checkOutput({tag, "_wb_rf_we"},  wb_rf_we,  0);
    checkOutput({tag, "_wb_rf_dst"}, wb_rf_dst, 0);
    checkOutput({tag, "_wb_hlt"},    wb_hlt,    0);
    checkOutput({tag, "_mem_err"},   mem_err,   0);
  endtask

  // Present one instruction and hold it until the sampler sees it accepted.
  task automatic applyStimulus(input logic [15:0] dst, input logic [15:0] sdata,
                               input logic rd, input logic wr, input logic rfWe,
                               input logic [3:0] rfDst, input logic hlt);
    int n;
    @(negedge clk);
    ex_dst    = dst;
    ex_sdata  = sdata;
    ex_mem_rd = rd;
    ex_mem_wr = wr;
    ex_rf_we  = rfWe;
    ex_rf_dst = rfDst;
    ex_hlt    = hlt;
    ex_valid  = 1'b1;
    accFlag   = 0;
    n = 0;
    while (!accFlag && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (!accFlag) checkOutput("accept_timeout", accFlag, 1);
  endtask

  // Idle cycles with junk on the EX fields, which must be ignored.
  task automatic idle(input int n);
    @(negedge clk);
    ex_valid  = 1'b0;
    ex_dst    = 16'($urandom);
    ex_sdata  = 16'($urandom);
    ex_mem_rd = 1'($urandom_range(0, 1));
    ex_mem_wr = 1'($urandom_range(0, 1));
    ex_rf_we  = 1'($urandom_range(0, 1));
    ex_rf_dst = 4'($urandom);
    ex_hlt    = 1'($urandom_range(0, 1));
    repeat (n) @(posedge clk);
  endtask

  task automatic doReset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs(tag);
    ex_valid = 1'b0;
    forceLat = -1;
    sbQ.delete();
    memQ.delete();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++) refMem[i] = dmMem[i];
    rst_n = 1'b1;
  endtask

  task automatic clearLogs();
    accCycLog.delete();
    wbCycLog.delete();
    stallCnt = 0;
    reqCnt = 0;
    wbCnt = 0;
    hltCnt = 0;
  endtask

  // Sampler: just before each rising edge, decide whether EX is taken and
  // compute the expected result from the program-order memory image.
  always begin
    wbExp_t  e;
    memExp_t m;
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (stall) stallCnt++;
      if (dm_req) reqCnt++;
      if (ex_valid && !stall) begin
        accFlag = 1;
        accCnt++;
        accCycLog.push_back(cyc + 1);
        e.rfDst = ex_rf_dst;
        e.hlt   = ex_hlt;
        if (ex_mem_wr) begin
          refMem[ex_dst[7:0]] = ex_sdata;
          e.data = ex_dst;
          e.rfWe = 1'b0;
          m.we = 1'b1; m.addr = ex_dst; m.wdata = ex_sdata;
          memQ.push_back(m);
        end else if (ex_mem_rd) begin
          e.data = refMem[ex_dst[7:0]];
          e.rfWe = ex_rf_we;
          m.we = 1'b0; m.addr = ex_dst; m.wdata = ex_sdata;
          memQ.push_back(m);
        end else begin
          e.data = ex_dst;
          e.rfWe = ex_rf_we;
        end
        sbQ.push_back(e);
      end
    end
  end

  // Memory responder: checks each new request against the expected access,
  // checks that the request is stable while waiting, and acks after the
  // chosen number of unanswered cycles. Spurious acks appear when idle.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      dm_ack = 1'b0;
      busy = 0;
    end else if (dm_req) begin
      if (!busy) begin
        busy = 1;
        left = (forceLat >= 0) ? forceLat : int'($urandom_range(0, 3));
        reqAddr = dm_addr;
        reqWe = dm_we;
        reqWdata = dm_wdata;
        if (memQ.size() == 0) begin
          checkOutput("dm_req_unexpected", dm_req, 0);
        end else begin
          respItem = memQ.pop_front();
          checkOutput("dm_we", dm_we, respItem.we);
          checkOutput("dm_addr", dm_addr, respItem.addr);
          if (respItem.we) checkOutput("dm_wdata", dm_wdata, respItem.wdata);
        end
      end else begin
        checkOutput("dm_addr_stable", dm_addr, reqAddr);
        checkOutput("dm_we_stable", dm_we, reqWe);
        checkOutput("dm_wdata_stable", dm_wdata, reqWdata);
      end
      if (left == 0) begin
        dm_ack = 1'b1;
        dm_rdata = dmMem[dm_addr[7:0]];
        if (dm_we) dmMem[dm_addr[7:0]] = dm_wdata;
        busy = 0;
      end else begin
        dm_ack = 1'b0;
        dm_rdata = 16'($urandom);
        left--;
      end
    end else begin
      dm_ack = ($urandom_range(0, 3) == 0);
      dm_rdata = 16'($urandom);
    end
  end

  // Monitor: every write-back pops the scoreboard; empty slots must be clean.
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (wb_valid) begin
        wbCnt++;
        wbCycLog.push_back(cyc);
        if (wb_hlt) hltCnt++;
        if (sbQ.size() == 0) begin
          checkOutput("wb_unexpected", wb_valid, 0);
        end else begin
          monItem = sbQ.pop_front();
          checkOutput("wb_data", wb_data, monItem.data);
          checkOutput("wb_rf_we", wb_rf_we, monItem.rfWe);
          checkOutput("wb_rf_dst", wb_rf_dst, monItem.rfDst);
          checkOutput("wb_hlt", wb_hlt, monItem.hlt);
        end
      end else begin
        checkOutput("bubble_we_hlt", {wb_rf_we, wb_hlt}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int prevAcc;
    logic [15:0] a;
    int kind;

    for (int i = 0; i < 256; i++) begin
      dmMem[i]  = 16'(i * 257) ^ 16'h5A5A;
      refMem[i] = dmMem[i];
    end

    // Power-on reset
    #1 rst_n = 1'b0;
    #2 checkResetOutputs("init");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU ops
    clearLogs();
    applyStimulus(16'h0011, 16'h0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    applyStimulus(16'h0022, 16'h0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
    idle(4);
    checkOutput("alu_wb_count", wbCnt, 2);
    checkOutput("alu_accept_b2b", accCycLog[1], accCycLog[0] + 1);
    checkOutput("alu_latency_a", wbCycLog[0], accCycLog[0] + 1);
    checkOutput("alu_latency_b", wbCycLog[1], accCycLog[1] + 1);

    // Load with three unanswered cycles
    dmMem[8'h40] = 16'hBEEF;
    refMem[8'h40] = 16'hBEEF;
    clearLogs();
    forceLat = 3;
    applyStimulus(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
    idle(8);
    forceLat = -1;
    checkOutput("load_req_cycles", reqCnt, 4);
    checkOutput("load_stall_cycles", stallCnt, 3);
    checkOutput("load_wb_count", wbCnt, 1);
    checkOutput("load_latency", wbCycLog[0], accCycLog[0] + 4);

    // Store with immediate ack followed by an ALU op
    clearLogs();
    forceLat = 0;
    applyStimulus(16'h0080, 16'h1234, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    applyStimulus(16'h0055, 16'h0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
    idle(5);
    forceLat = -1;
    checkOutput("store_stall_cycles", stallCnt, 0);
    checkOutput("store_wb_count", wbCnt, 2);
    checkOutput("store_alu_b2b", wbCycLog[1], wbCycLog[0] + 1);
    checkOutput("store_latency", wbCycLog[0], accCycLog[0] + 1);

    // Ack in the last allowed cycle, then halt and one more op
    clearLogs();
    forceLat = MaxWait - 1;
    applyStimulus(16'h0033, 16'h0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
    applyStimulus(16'h0077, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    forceLat = -1;
    applyStimulus(16'h0099, 16'h0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    idle(6);
    checkOutput("edge_ack_no_err", mem_err, 0);
    checkOutput("edge_req_cycles", reqCnt, MaxWait);
    checkOutput("edge_stall_cycles", stallCnt, MaxWait - 1);
    checkOutput("halt_pulses", hltCnt, 1);
    checkOutput("edge_wb_count", wbCnt, 3);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 19);
      a = 16'($urandom);
      if (kind < 8)
        applyStimulus(a, 16'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 15) == 0));
      else if (kind < 14)
        applyStimulus(a, 16'($urandom), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
      else if (kind < 19)
        applyStimulus(a, 16'($urandom), 1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
      else
        applyStimulus(a, 16'($urandom), 1'b1, 1'b1, 1'b1, 4'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(20);
    checkOutput("random_sb_drained", sbQ.size(), 0);
    checkOutput("random_mem_drained", memQ.size(), 0);
    checkOutput("random_no_err", mem_err, 0);

    // Reset in the middle of an outstanding access
    forceLat = 6;
    applyStimulus(16'h0021, 16'h0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    @(posedge clk);
    #1 checkOutput("midaccess_req", dm_req, 1);
    doReset("midreset");
    idle(3);

    // Memory never answers
    clearLogs();
    forceLat = 1000;
    applyStimulus(16'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0);
    n = 0;
    while (!mem_err && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("timeout_mem_err", mem_err, 1);
    checkOutput("timeout_req_cycles", reqCnt, MaxWait);
    checkOutput("timeout_dm_req", dm_req, 0);
    checkOutput("timeout_stall", stall, 1);
    prevAcc = accCnt;
    @(negedge clk);
    ex_valid = 1'b1;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("err_stall_held", stall, 1);
      checkOutput("err_sticky", mem_err, 1);
    end
    checkOutput("err_no_accept", accCnt, prevAcc);
    doReset("errreset");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
